mac_pipe_unit: RTL and testbench

- Pipelined, parametrised multiply-accumulate engine. Successor to the combinational multiplier.
- Computes one KERNEL_SIZE-tap dot product (sum of data0*data1) per result, for the CNN convolution datapath.
- Supports signed or unsigned operands, and saturating or wrapping accumulation.
- Valid/ready handshakes on input and output; sits between the window/weight fetch logic and the activation stage.

---
 rtl/mac_pipe_unit.sv | 113 +++++++++++
 tb/tb_mac_pipe_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pipe_unit.sv
// Two-stage pipelined multiply-accumulate: stage 1 registers one product per tap,
// stage 2 accumulates KERNEL_SIZE products and presents the dot product on a valid/ready port.
module mac_pipe_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 20,
  parameter int KERNEL_SIZE = 9,
  parameter bit SIGNED      = 1'b1,
  parameter bit SATURATE    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_ovf
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [CW-1:0] LAST_TAP = CW'(KERNEL_SIZE - 1);

  localparam logic [ACC_WIDTH-1:0] S_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] S_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0] U_MAX = {ACC_WIDTH{1'b1}};

  logic                  stall;
  logic [CW-1:0]         tap_cnt;
  logic [PW-1:0]         prod_s;
  logic [PW-1:0]         prod_u;
  logic [PW-1:0]         prod_r;
  logic                  p_valid;
  logic                  p_last;
  logic [ACC_WIDTH-1:0]  acc;
  logic                  ovf;
  logic [ACC_WIDTH:0]    prod_ext;
  logic [ACC_WIDTH:0]    sum;
  logic                  step_ovf;
  logic [ACC_WIDTH-1:0]  result;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Operands are widened before the multiply so the product keeps full precision.
  assign prod_s = PW'($signed(data0)) * PW'($signed(data1));
  assign prod_u = PW'(data0) * PW'(data1);

  // NOTE: always_comb assigns every output first so no path can infer a latch.
  always_comb begin
    prod_ext = {{(ACC_WIDTH + 1 - PW){SIGNED & prod_r[PW-1]}}, prod_r};
    sum      = {SIGNED & acc[ACC_WIDTH-1], acc} + prod_ext;
    step_ovf = SIGNED ? (sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1]) : sum[ACC_WIDTH];
    result   = sum[ACC_WIDTH-1:0];
    if (step_ovf && SATURATE) begin
      if (SIGNED) result = sum[ACC_WIDTH] ? S_MIN : S_MAX;
      else        result = U_MAX;
    end
  end

  // NOTE: pipeline state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt <= '0;
      // NOTE: the product register is reset too, although its contents are ignored until p_valid.
      prod_r  <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else if (flush) begin
      tap_cnt <= '0;
      p_valid <= 1'b0;
    end else if (!stall) begin
      p_valid <= in_valid;
      if (in_valid) begin
        prod_r  <= SIGNED ? prod_s : prod_u;
        p_last  <= (tap_cnt == LAST_TAP);
        tap_cnt <= (tap_cnt == LAST_TAP) ? '0 : tap_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (flush) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (!stall && p_valid) begin
        if (p_last) begin
          out_data <= result;
          out_ovf  <= ovf | step_ovf;
          acc      <= '0;
          ovf      <= 1'b0;
        end else begin
          acc <= result;
          ovf <= ovf | step_ovf;
        end
      end
      // A result completing on the same edge as a consumed one keeps out_valid high.
      if (!flush && !stall && p_valid && p_last) out_valid <= 1'b1;
      else if (out_ready)                        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_pipe_unit.sv
// Bench for mac_pipe_unit: four parameter variants share one stimulus stream and are
// compared every cycle against a tap-level dot-product model, plus literal spot checks.
module tb_mac_pipe_unit;

  localparam int K  = 9;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [7:0] data0 = '0;
  logic [7:0] data1 = '0;

  logic [NI-1:0] in_ready_v, out_valid_v, out_ovf_v;
  logic [19:0] od0;
  logic [15:0] od1, od2, od3;
  logic [63:0] act_data [NI];

  int n_tests = 0;
  int n_fail  = 0;

  // Variant table: 0 = defaults, 1 = 16-bit saturating, 2 = 16-bit wrapping, 3 = 16-bit unsigned saturating.
  int aw_c  [NI] = '{20, 16, 16, 16};
  bit sgn_c [NI] = '{1, 1, 1, 0};
  bit sat_c [NI] = '{1, 1, 0, 1};

  always #5 clk = ~clk;

  mac_pipe_unit #(.DATA_WIDTH(8), .ACC_WIDTH(20), .KERNEL_SIZE(K), .SIGNED(1'b1), .SATURATE(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .data0(data0), .data1(data1), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .out_data(od0), .out_ovf(out_ovf_v[0]));
  mac_pipe_unit #(.DATA_WIDTH(8), .ACC_WIDTH(16), .KERNEL_SIZE(K), .SIGNED(1'b1), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .data0(data0), .data1(data1), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .out_data(od1), .out_ovf(out_ovf_v[1]));
  mac_pipe_unit #(.DATA_WIDTH(8), .ACC_WIDTH(16), .KERNEL_SIZE(K), .SIGNED(1'b1), .SATURATE(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .data0(data0), .data1(data1), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .out_data(od2), .out_ovf(out_ovf_v[2]));
  mac_pipe_unit #(.DATA_WIDTH(8), .ACC_WIDTH(16), .KERNEL_SIZE(K), .SIGNED(1'b0), .SATURATE(1'b1)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_v[3]),
    .data0(data0), .data1(data1), .out_valid(out_valid_v[3]), .out_ready(out_ready),
    .out_data(od3), .out_ovf(out_ovf_v[3]));

  always_comb begin
    act_data[0] = 64'(od0);
    act_data[1] = 64'(od1);
    act_data[2] = 64'(od2);
    act_data[3] = 64'(od3);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] cur_a[$];
  logic [7:0] cur_b[$];
  logic [7:0] pk_a [K];
  logic [7:0] pk_b [K];
  bit         pending;
  bit         m_valid;
  bit         m_st, m_hs;
  longint     m_data [NI];
  bit         m_ovf  [NI];

  // Dot product of the completed kernel with the variant's overflow rule applied tap by tap.
  function automatic void kernel_result(input int i, output longint d, output bit o);
    longint acc, s, a, b, mx, mn, span;
    span = longint'(1) << aw_c[i];
    mx   = sgn_c[i] ? (span / 2 - 1) : (span - 1);
    mn   = sgn_c[i] ? -(span / 2) : 0;
    acc  = 0;
    o    = 1'b0;
    for (int t = 0; t < K; t++) begin
      a = sgn_c[i] ? longint'($signed(pk_a[t])) : longint'(pk_a[t]);
      b = sgn_c[i] ? longint'($signed(pk_b[t])) : longint'(pk_b[t]);
      s = acc + a * b;
      if (s > mx || s < mn) begin
        o = 1'b1;
        if (sat_c[i]) s = (s > mx) ? mx : mn;
        else begin
          s = s & (span - 1);
          if (s > mx) s -= span;
        end
      end
      acc = s;
    end
    d = acc & (span - 1);
  endfunction

  initial begin
    pending = 1'b0;
    m_valid = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cur_a.delete();
        cur_b.delete();
        pending = 1'b0;
        m_valid = 1'b0;
        for (int i = 0; i < NI; i++) begin
          m_data[i] = 0;
          m_ovf[i]  = 1'b0;
        end
      end else begin
        m_st = m_valid && !out_ready;
        m_hs = in_valid && !m_st && !flush;
        if (!flush && !m_st && pending) begin
          for (int i = 0; i < NI; i++) kernel_result(i, m_data[i], m_ovf[i]);
          m_valid = 1'b1;
          pending = 1'b0;
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
        end
        if (flush) begin
          cur_a.delete();
          cur_b.delete();
          pending = 1'b0;
        end
        if (m_hs) begin
          cur_a.push_back(data0);
          cur_b.push_back(data1);
          if (cur_a.size() == K) begin
            for (int t = 0; t < K; t++) begin
              pk_a[t] = cur_a[t];
              pk_b[t] = cur_b[t];
            end
            cur_a.delete();
            cur_b.delete();
            pending = 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < NI; i++) begin
          check($sformatf("out_valid[%0d]", i), 64'(out_valid_v[i]), 64'(m_valid));
          check($sformatf("in_ready[%0d]", i), 64'(in_ready_v[i]), 64'(!(m_valid && !out_ready)));
          if (m_valid) begin
            check($sformatf("out_data[%0d]", i), act_data[i], 64'(m_data[i]));
            check($sformatf("out_ovf[%0d]", i), 64'(out_ovf_v[i]), 64'(m_ovf[i]));
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int tries;
    tries    = 0;
    data0    = a;
    data1    = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready_v[0]) begin
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      tries++;
      if (tries > 60) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready 0 expected 1 within 60 cycles");
        break;
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid_v[0] && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid_v[0]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got out_valid 0 expected 1 within 60 cycles", tag);
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  int         vcnt;
  logic [63:0] vcap;

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid_v[0]), 64'd0);
    check("rst_out_data", act_data[0], 64'd0);
    check("rst_out_ovf", 64'(out_ovf_v[0]), 64'd0);
    check("rst_in_ready", 64'(in_ready_v[0]), 64'd1);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Data0 = 1..9 times 2, with exact latency
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) send(8'(i), 8'd2);
    idle();
    @(negedge clk);
    check("t1_valid_early", 64'(out_valid_v[0]), 64'd0);
    @(negedge clk);
    check("t1_valid", 64'(out_valid_v[0]), 64'd1);
    check("t1_data", act_data[0], 64'd90);
    check("t1_ovf", 64'(out_ovf_v[0]), 64'd0);
    @(negedge clk);
    check("t1_valid_one_cycle", 64'(out_valid_v[0]), 64'd0);
    settle();

    // Negative operand
    for (int i = 0; i < 9; i++) send(8'hFD, 8'd7);
    idle();
    wait_valid("t2");
    check("t2_data", act_data[0], 64'h0FFF43);
    check("t2_ovf", 64'(out_ovf_v[0]), 64'd0);
    settle();

    // Back-to-back kernels with output back-pressure
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 9; i++) send(8'd1, 8'd1);
        for (int i = 0; i < 9; i++) send(8'd5, 8'd1);
        idle();
      end
      begin
        wait_valid("t3a");
        for (int i = 0; i < 5; i++) begin
          check("t3_hold_data", act_data[0], 64'd9);
          check("t3_stall_ready", 64'(in_ready_v[0]), 64'd0);
          if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        wait_valid("t3b");
        check("t3_b_data", act_data[0], 64'd45);
      end
    join
    settle();

    // 127*127 taps: saturating and wrapping 16-bit variants
    for (int i = 0; i < 9; i++) send(8'd127, 8'd127);
    idle();
    wait_valid("t4");
    check("t4_def_data", act_data[0], 64'd145161);
    check("t4_def_ovf", 64'(out_ovf_v[0]), 64'd0);
    check("t4_sat_data", act_data[1], 64'd32767);
    check("t4_sat_ovf", 64'(out_ovf_v[1]), 64'd1);
    check("t4_wrap_data", act_data[2], 64'd14089);
    check("t4_wrap_ovf", 64'(out_ovf_v[2]), 64'd1);
    settle();

    // Flush discards partial kernel and the tap presented with it
    vcnt = 0;
    vcap = '0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(8'd3, 8'd3);
        flush    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        for (int i = 0; i < 9; i++) send(8'd1, 8'd1);
        idle();
      end
      begin
        repeat (30) begin
          @(negedge clk);
          if (out_valid_v[0]) begin
            vcnt++;
            vcap = act_data[0];
          end
        end
      end
    join
    check("t5_result_count", 64'(vcnt), 64'd1);
    check("t5_data", vcap, 64'd9);
    settle();

    // Asynchronous reset mid-kernel
    for (int i = 0; i < 5; i++) send(8'd1, 8'd1);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_data", act_data[0], 64'd0);
    check("t6_rst_valid", 64'(out_valid_v[0]), 64'd0);
    check("t6_rst_ovf", 64'(out_ovf_v[0]), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) send(8'd2, 8'd2);
    idle();
    wait_valid("t6");
    check("t6_data", act_data[0], 64'd36);
    settle();

    // Randomized traffic with back-pressure and occasional flushes
    for (int c = 0; c < 1200; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      data0     = ($urandom_range(0, 3) == 0) ? 8'h7F : 8'($urandom);
      data1     = ($urandom_range(0, 3) == 0) ? 8'h81 : 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
    end
    idle();
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
